// File: rtl/eth_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eth_pkg : shared Ethernet constants, address type and tx framer states
// Rev 1.0
// ---------------------------------------------------------------------------
package eth_pkg;

  localparam int          MAC_W           = 48;
  localparam int          ETH_HDR_LEN     = 14;
  localparam int          ETH_MIN_PAYLOAD = 46;
  localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;

  typedef logic [MAC_W-1:0] mac_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DST     = 3'd1,
    ST_SRC     = 3'd2,
    ST_TYPE    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_PAD     = 3'd5
  } eth_tx_state_t;

  // Byte idx of an address on the wire; index 0 is the most significant byte.
  function automatic logic [7:0] mac_byte(input mac_addr_t mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_framer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eth_tx_framer_if : byte-wide AXI-Stream link (data, valid, ready, last)
// Rev 1.0
// ---------------------------------------------------------------------------
interface eth_tx_framer_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/eth_tx_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eth_tx_framer : prepends dst/src MAC and EtherType to a payload stream and
//                 zero-pads short payloads to the minimum length
// Rev 1.0
// ---------------------------------------------------------------------------
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter mac_addr_t   SRC_MAC     = 48'h0C_0D_0E_0F_10_11,
  parameter logic [15:0] ETHERTYPE   = ETH_TYPE_IPV4,
  parameter int          MIN_PAYLOAD = ETH_MIN_PAYLOAD
) (
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire mac_addr_t dst_mac,
  eth_tx_framer_if.slave  s_axis,
  eth_tx_framer_if.master m_axis,
  output logic           busy
);

  localparam logic [11:0] c_min_pay = 12'(MIN_PAYLOAD);
  localparam logic [10:0] c_cnt_max = 11'h7FF;

  eth_tx_state_t r_state;
  logic [2:0]    r_idx;
  logic [10:0]   r_cnt;
  mac_addr_t     r_dst;
  logic          r_busy;

  logic [7:0]    w_tdata;
  logic          w_tvalid;
  logic          w_tlast;
  logic          w_s_tready;
  logic          w_hs;
  logic [11:0]   w_cnt_inc;
  logic [10:0]   w_cnt_sat;

  assign w_cnt_inc = {1'b0, r_cnt} + 12'd1;
  assign w_cnt_sat = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 11'd1;
  assign w_hs      = w_tvalid && m_axis.tready;

  // Header bytes come from the state/index mux; payload is a straight pass-through.
  always_comb begin
    w_tdata    = 8'h00;
    w_tvalid   = 1'b0;
    w_tlast    = 1'b0;
    w_s_tready = 1'b0;
    case (r_state)
      ST_DST: begin
        w_tvalid = 1'b1;
        w_tdata  = mac_byte(r_dst, r_idx);
      end
      ST_SRC: begin
        w_tvalid = 1'b1;
        w_tdata  = mac_byte(SRC_MAC, r_idx);
      end
      ST_TYPE: begin
        w_tvalid = 1'b1;
        w_tdata  = r_idx[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
      end
      ST_PAYLOAD: begin
        w_tvalid   = s_axis.tvalid;
        w_tdata    = s_axis.tdata;
        w_s_tready = m_axis.tready;
        w_tlast    = s_axis.tlast && (w_cnt_inc >= c_min_pay);
      end
      ST_PAD: begin
        w_tvalid = 1'b1;
        w_tlast  = (w_cnt_inc == c_min_pay);
      end
      default: begin
        w_tvalid = 1'b0;
      end
    endcase
  end

  assign m_axis.tdata  = w_tdata;
  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tlast  = w_tlast;
  assign s_axis.tready = w_s_tready;
  assign busy          = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 11'd0;
      r_dst   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_idx <= 3'd0;
          r_cnt <= 11'd0;
          if (s_axis.tvalid) begin
            r_dst   <= dst_mac;
            r_busy  <= 1'b1;
            r_state <= ST_DST;
          end
        end
        ST_DST, ST_SRC: begin
          if (w_hs) begin
            if (r_idx == 3'd5) begin
              r_idx   <= 3'd0;
              r_state <= (r_state == ST_DST) ? ST_SRC : ST_TYPE;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_TYPE: begin
          if (w_hs) begin
            if (r_idx == 3'd1) begin
              r_idx   <= 3'd0;
              r_state <= ST_PAYLOAD;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_hs) begin
            r_cnt <= w_cnt_sat;
            if (s_axis.tlast) begin
              if (w_cnt_inc >= c_min_pay) begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          if (w_hs) begin
            r_cnt <= w_cnt_sat;
            if (w_tlast) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_eth_tx_framer : scoreboard bench; driver queues expected frames, monitor
//                    pops and compares on every output handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_eth_tx_framer;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       hdr_pad;
    logic       gap;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [47:0] dst_mac;
  logic        busy;

  eth_tx_framer_if s_if ();
  eth_tx_framer_if m_if ();

  eth_tx_framer dut (
    .clk     (clk),
    .rst     (rst),
    .dst_mac (dst_mac),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [7:0]  pay[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_end = 0;
  bit          toggle_mode = 1'b0;
  logic [47:0] dst_next;

  bit          prev_stall = 1'b0;
  logic [7:0]  prev_d;
  logic        prev_l;

  // Monitor: compare every output handshake against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst) begin
      if (prev_stall) begin
        checks = checks + 1;
        if (!m_if.tvalid || m_if.tdata !== prev_d || m_if.tlast !== prev_l) begin
          errors = errors + 1;
          $display("FAIL stall_stable: got v=%0b d=%02h l=%0b need v=1 d=%02h l=%0b",
                   m_if.tvalid, m_if.tdata, m_if.tlast, prev_d, prev_l);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_byte: got d=%02h l=%0b need nothing", m_if.tdata, m_if.tlast);
        end else begin
          e = sb.pop_front();
          if (m_if.tdata !== e.d || m_if.tlast !== e.l) begin
            errors = errors + 1;
            $display("FAIL frame_byte: got d=%02h l=%0b need d=%02h l=%0b",
                     m_if.tdata, m_if.tlast, e.d, e.l);
          end
          checks = checks + 1;
          if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL busy_in_frame: got %0b need 1", busy);
          end
          if (e.hdr_pad) begin
            checks = checks + 1;
            if (s_if.tready !== 1'b0) begin
              errors = errors + 1;
              $display("FAIL s_tready_hdr_pad: got %0b need 0", s_if.tready);
            end
          end
          if (e.gap) begin
            checks = checks + 1;
            if (cyc - last_end != 2) begin
              errors = errors + 1;
              $display("FAIL b2b_gap: got %0d need 2", cyc - last_end);
            end
          end
        end
        if (m_if.tlast) last_end = cyc;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_d     = m_if.tdata;
      prev_l     = m_if.tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Downstream ready: constant 1 or toggling every cycle
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = toggle_mode ? ~m_if.tready : 1'b1;
    end
  end

  task automatic fill(input int n, input int base);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(base + i));
  endtask

  // Push the expected frame for the current payload; limit truncates the push
  task automatic push_exp(input logic [47:0] d, input bit gap, input int limit);
    logic [47:0] src;
    logic [15:0] et;
    int          n;
    exp_t        e;
    src = 48'h0C0D0E0F1011;
    et  = 16'h0800;
    n   = pay.size();
    for (int i = 0; i < 6; i++) begin
      e = '{d: d[47-8*i -: 8], l: 1'b0, hdr_pad: 1'b1, gap: (gap && i == 0)};
      sb.push_back(e);
    end
    for (int i = 0; i < 6; i++) sb.push_back('{d: src[47-8*i -: 8], l: 1'b0, hdr_pad: 1'b1, gap: 1'b0});
    sb.push_back('{d: et[15:8], l: 1'b0, hdr_pad: 1'b1, gap: 1'b0});
    sb.push_back('{d: et[7:0],  l: 1'b0, hdr_pad: 1'b1, gap: 1'b0});
    for (int i = 0; i < n && i < limit; i++)
      sb.push_back('{d: pay[i], l: (i == n - 1 && n >= 46), hdr_pad: 1'b0, gap: 1'b0});
    if (limit >= n)
      for (int i = n; i < 46; i++) sb.push_back('{d: 8'h00, l: (i == 45), hdr_pad: 1'b1, gap: 1'b0});
  endtask

  // Drive n_send payload bytes; hold keeps s_tvalid high after the last one
  task automatic drive(input int n_send, input bit hold, input bit chg);
    int budget;
    bit hs;
    for (int i = 0; i < n_send; i++) begin
      s_if.tdata  = pay[i];
      s_if.tlast  = (i == pay.size() - 1);
      s_if.tvalid = 1'b1;
      if (chg && i == 5) dst_mac = dst_next;
      hs     = 1'b0;
      budget = 500;
      while (!hs && budget > 0) begin
        @(negedge clk);
        hs = s_if.tready;
        @(posedge clk);
        #1;
        budget--;
      end
      if (!hs) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL hs_timeout: byte %0d got no handshake need one", i);
      end
    end
    if (!hold) begin
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 500;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain_%s: got %0d bytes pending need 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks = checks + 1;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || busy !== 1'b0 ||
        m_if.tlast !== 1'b0 || m_if.tdata !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL idle_%s: got v=%0b r=%0b busy=%0b l=%0b d=%02h need all 0",
               name, m_if.tvalid, s_if.tready, busy, m_if.tlast, m_if.tdata);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    dst_mac     = 48'h010203040506;
    dst_next    = 48'h0;
    s_if.tdata  = 8'h00;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    check_idle("after_reset");

    // 50-byte payload, no pad
    fill(50, 0);
    push_exp(dst_mac, 1'b0, 1000);
    drive(50, 1'b0, 1'b0);
    drain("s1");

    // 10-byte payload padded to 46
    fill(10, 5);
    push_exp(dst_mac, 1'b0, 1000);
    drive(10, 1'b0, 1'b0);
    drain("s2");

    // exactly minimum, then one short of it
    fill(46, 100);
    push_exp(dst_mac, 1'b0, 1000);
    drive(46, 1'b0, 1'b0);
    drain("s3a");
    fill(45, 150);
    push_exp(dst_mac, 1'b0, 1000);
    drive(45, 1'b0, 1'b0);
    drain("s3b");

    // backpressure toggling every cycle
    toggle_mode = 1'b1;
    fill(10, 5);
    push_exp(dst_mac, 1'b0, 1000);
    drive(10, 1'b0, 1'b0);
    drain("s4");
    toggle_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset mid-payload after 20 bytes
    fill(30, 0);
    push_exp(dst_mac, 1'b0, 20);
    drive(20, 1'b0, 1'b0);
    drain("s5_partial");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("s5_after_rst");
    dst_mac = 48'h660C0D0E0F10;
    fill(12, 32);
    push_exp(dst_mac, 1'b0, 1000);
    drive(12, 1'b0, 1'b0);
    drain("s5_restart");

    // back-to-back frames, dst_mac changed during the first payload
    dst_mac  = 48'hA1A2A3A4A5A6;
    dst_next = 48'hB1B2B3B4B5B6;
    fill(10, 200);
    push_exp(48'hA1A2A3A4A5A6, 1'b0, 1000);
    drive(10, 1'b1, 1'b1);
    fill(48, 60);
    push_exp(48'hB1B2B3B4B5B6, 1'b1, 1000);
    drive(48, 1'b0, 1'b0);
    drain("s6");
    check_idle("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
AXI-Stream byte-wide Ethernet transmit framer; the transmit-side counterpart of eth_rx_buffer.
- Accepts a raw payload stream on the slave port.
- Prepends destination MAC, source MAC and EtherType.
- Zero-pads short payloads to the 46-byte minimum.
- Emits the complete frame (no preamble, no FCS) on the master port toward the MAC/PHY.

Parameters:
SRC_MAC, 48'h0C_0D_0E_0F_10_11, station source address, sent MSB byte first
ETHERTYPE, 16'h0800, EtherType field, sent MSB byte first
MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded up to this

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
dst_mac  in  48  destination address, sampled when a frame starts
s_tdata  in  8  payload byte
s_tvalid  in  1  payload byte valid
s_tready  out  1  framer accepts payload byte
s_tlast  in  1  last payload byte of frame
m_tdata  out  8  frame byte
m_tvalid  out  1  frame byte valid
m_tready  in  1  downstream accepts byte
m_tlast  out  1  last byte of frame
busy  out  1  high from frame start until final m_tvalid&&m_tready handshake

Behaviour:
- Reset (synchronous, rst=1 on a clk edge):
  - Outputs go to m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, busy=0.
  - State returns to IDLE; counters clear.
  - Reset mid-frame aborts the frame with no m_tlast; the truncated frame is the downstream's responsibility.
- States: IDLE, DST, SRC, TYPE, PAYLOAD, PAD.
- Byte index counter: 0..5 within DST and SRC, 0..1 within TYPE.
- Payload counter: 11 bits, saturating at 2047. No maximum-length enforcement.
- IDLE:
  - m_tvalid=0 and s_tready=0.
  - If s_tvalid=1, latch dst_mac into dst_q, go to DST and set busy.
  - Latency: first header byte is valid on the cycle after s_tvalid is seen in IDLE.
  - The first payload byte is not consumed in IDLE.
- DST, SRC, TYPE:
  - m_tvalid=1, s_tready=0.
  - m_tdata is dst_q, SRC_MAC or ETHERTYPE, byte [index], MSB first.
  - The index advances only on an m_tvalid&&m_tready handshake; after its last byte each state moves to the next.
- PAYLOAD (combinational pass-through):
  - m_tvalid=s_tvalid, m_tdata=s_tdata, s_tready=m_tready.
  - Payload counter increments per handshake.
  - On a handshake with s_tlast=1:
    - If count+1 >= MIN_PAYLOAD: m_tlast=1, next state IDLE.
    - Otherwise: m_tlast=0, next state PAD.
- PAD:
  - m_tvalid=1, m_tdata=8'h00, s_tready=0.
  - Counter increments per handshake.
  - m_tlast=1 on the byte where count+1 == MIN_PAYLOAD; after that handshake go to IDLE.
- AXI rules:
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast stay stable; state advances only on a handshake.
  - s_tready never depends on s_tvalid.
- dst_mac changes after frame start have no effect on the frame in flight.
- Throughput: 1 byte/cycle with m_tready=1. One idle bubble cycle follows each frame (passing through IDLE).
- Frame length:
  - 14 + max(payload, MIN_PAYLOAD) bytes.
  - Minimum 60 bytes.
  - A payload is always at least 1 byte.

Decomposition:
- Package eth_pkg holds:
  - constants MAC_W=48, ETH_HDR_LEN=14, ETH_MIN_PAYLOAD=46, ETH_TYPE_IPV4=16'h0800;
  - the state enum typedef eth_tx_state_t;
  - typedef mac_addr_t = logic[47:0].
- eth_rx_buffer also imports MAC_W and mac_addr_t from eth_pkg.
- No sub-module: header byte selection is a local mux inside eth_tx_framer.

Test Plan:
1. dst_mac=01:02:03:04:05:06; 50-byte payload 00..31; m_tready=1.
   -> Output 01..06, 0C..11, 08, 00, then 00..31; m_tlast only on byte 64; no pad.
2. 10-byte payload 05..0E.
   -> 14 header bytes, 05..0E, then 36 bytes of 00; m_tlast only on byte 60; s_tready=0 throughout pad.
3. Exactly 46-byte payload.
   -> No pad; m_tlast on the 46th payload byte (frame byte 60). 45-byte payload -> exactly 1 pad byte carrying m_tlast.
4. Repeat scenario 2 with m_tready toggling 1/0 every cycle.
   -> Identical byte sequence; m_tdata and m_tlast stable whenever m_tvalid=1 and m_tready=0; no payload byte lost or duplicated.
5. rst=1 for one cycle at payload byte 20.
   -> Next cycle m_tvalid=0, s_tready=0, busy=0. A following frame with dst_mac=66:0C:0D:0E:0F:10 starts cleanly with header byte 66.
6. Back-to-back frames (s_tvalid held high); dst_mac changed during the first frame's payload.
   -> First frame keeps its latched dst; one idle cycle separates the frames; second frame carries the new dst_mac.
